ycbcr_skin_filter: RTL and testbench

YCBCR_SKIN_FILTER -- requirements
Module: ycbcr_skin_filter

---
 rtl/ycbcr_pkg.sv | 58 +++++
 rtl/csc_mac3.sv | 50 +++++
 rtl/ycbcr_skin_filter.sv | 202 ++++++++++++++++++++
 tb/tb_ycbcr_skin_filter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ycbcr_pkg.sv
// Shared constants and types for the YCbCr skin filter: default coefficients,
// default thresholds, output mode encodings and the CSC offsets.
package ycbcr_pkg;

    localparam logic signed [11:0] KY_R_DEF  =  12'sd263;
    localparam logic signed [11:0] KY_G_DEF  =  12'sd516;
    localparam logic signed [11:0] KY_B_DEF  =  12'sd100;
    localparam logic signed [11:0] KCB_R_DEF = -12'sd152;
    localparam logic signed [11:0] KCB_G_DEF = -12'sd298;
    localparam logic signed [11:0] KCB_B_DEF =  12'sd450;
    localparam logic signed [11:0] KCR_R_DEF =  12'sd450;
    localparam logic signed [11:0] KCR_G_DEF = -12'sd377;
    localparam logic signed [11:0] KCR_B_DEF = -12'sd73;

    localparam int unsigned Y_OFFSET = 16;
    localparam int unsigned C_OFFSET = 128;

    // Width of a shifted CSC result; independent of DW since the shift tracks DW.
    localparam int CSC_RW = 14;

    localparam logic [7:0] CR_LO_DEF = 8'd133;
    localparam logic [7:0] CR_HI_DEF = 8'd179;
    localparam logic [7:0] CB_LO_DEF = 8'd91;
    localparam logic [7:0] CB_HI_DEF = 8'd111;

    typedef enum logic [1:0] {
        ModeMask    = 2'd0,
        ModeYcc     = 2'd1,
        ModeSkinRgb = 2'd2,
        ModeBypass  = 2'd3
    } mode_e;

    typedef struct packed {
        logic [7:0] cr_lo;
        logic [7:0] cr_hi;
        logic [7:0] cb_lo;
        logic [7:0] cb_hi;
    } thr_t;

    typedef struct packed {
        mode_e mode;
        thr_t  thr;
    } cfg_t;

    localparam thr_t THR_DEF = '{cr_lo: CR_LO_DEF, cr_hi: CR_HI_DEF,
                                 cb_lo: CB_LO_DEF, cb_hi: CB_HI_DEF};

    function automatic logic [7:0] clamp_u8(input logic signed [31:0] v);
        if (v < 0) begin
            return 8'd0;
        end
        if (v > 255) begin
            return 8'hff;
        end
        return v[7:0];
    endfunction

endpackage

// File: rtl/csc_mac3.sv
// Two-cycle 3-term signed multiply-accumulate: registered products, then
// registered (sum + offset) arithmetically shifted down by DW+2.
module csc_mac3
    import ycbcr_pkg::*;
#(
    parameter int                 DW  = 10,
    parameter int unsigned        OFF = 16,
    parameter logic signed [11:0] K_R = 12'sd0,
    parameter logic signed [11:0] K_G = 12'sd0,
    parameter logic signed [11:0] K_B = 12'sd0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [DW-1:0]            i_r,
    input  logic [DW-1:0]            i_g,
    input  logic [DW-1:0]            i_b,
    output logic signed [CSC_RW-1:0] o_res
);

    localparam int SH = DW + 2;
    localparam int PW = DW + 13;
    localparam int SW = DW + 16;
    localparam logic signed [SW-1:0] OFFS = SW'(OFF) << SH;

    logic signed [PW-1:0]     r_pr, r_pg, r_pb;
    logic signed [SW-1:0]     w_sum;
    logic signed [CSC_RW-1:0] r_res;

    always_comb begin
        w_sum = SW'(r_pr) + SW'(r_pg) + SW'(r_pb) + OFFS;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pr  <= '0;
            r_pg  <= '0;
            r_pb  <= '0;
            r_res <= '0;
        end else begin
            // Components are unsigned; widen with a zero sign bit before the signed multiply.
            r_pr  <= PW'(K_R) * PW'($signed({1'b0, i_r}));
            r_pg  <= PW'(K_G) * PW'($signed({1'b0, i_g}));
            r_pb  <= PW'(K_B) * PW'($signed({1'b0, i_b}));
            r_res <= CSC_RW'(w_sum >>> SH);
        end
    end

    assign o_res = r_res;

endmodule

// File: rtl/ycbcr_skin_filter.sv
// RGB -> YCbCr skin detector: 4-stage pipeline with per-frame configuration
// latched at SOF and a per-frame skin-pixel counter.
module ycbcr_skin_filter
    import ycbcr_pkg::*;
#(
    parameter int                 DW    = 10,
    parameter int                 CNTW  = 20,
    parameter logic signed [11:0] KY_R  = KY_R_DEF,
    parameter logic signed [11:0] KY_G  = KY_G_DEF,
    parameter logic signed [11:0] KY_B  = KY_B_DEF,
    parameter logic signed [11:0] KCB_R = KCB_R_DEF,
    parameter logic signed [11:0] KCB_G = KCB_G_DEF,
    parameter logic signed [11:0] KCB_B = KCB_B_DEF,
    parameter logic signed [11:0] KCR_R = KCR_R_DEF,
    parameter logic signed [11:0] KCR_G = KCR_G_DEF,
    parameter logic signed [11:0] KCR_B = KCR_B_DEF
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iValid,
    input  logic            iSOF,
    input  logic            iEOF,
    input  logic [DW-1:0]   iRed,
    input  logic [DW-1:0]   iGreen,
    input  logic [DW-1:0]   iBlue,
    input  logic [1:0]      iMode,
    input  logic            iCfgWe,
    input  logic [1:0]      iCfgAddr,
    input  logic [7:0]      iCfgData,
    output logic            oValid,
    output logic            oSOF,
    output logic            oEOF,
    output logic [DW-1:0]   oRed,
    output logic [DW-1:0]   oGreen,
    output logic [DW-1:0]   oBlue,
    output logic            oSkin,
    output logic [CNTW-1:0] oSkinCount,
    output logic            oCountValid
);

    localparam logic [DW-1:0] MASK_ON = DW'(255) << (DW - 8);

    typedef struct packed {
        logic          v;
        logic          sof;
        logic          eof;
        logic [DW-1:0] r;
        logic [DW-1:0] g;
        logic [DW-1:0] b;
        cfg_t          cfg;
    } pix_t;

    pix_t                     w_p0, r_p1, r_p2, r_p3;
    thr_t                     r_shadow;
    cfg_t                     r_act;
    logic signed [CSC_RW-1:0] w_y2, w_cb2, w_cr2;
    logic [7:0]               r_y3, r_cb3, r_cr3;
    logic                     w_skin;
    logic [DW-1:0]            w_r, w_g, w_b;
    logic [CNTW-1:0]          r_cnt, w_cnt_base, w_cnt_next;

    // The SOF pixel already uses the config it is about to install.
    always_comb begin
        w_p0.v   = iValid;
        w_p0.sof = iSOF;
        w_p0.eof = iEOF;
        w_p0.r   = iRed;
        w_p0.g   = iGreen;
        w_p0.b   = iBlue;
        w_p0.cfg = r_act;
        if (iValid && iSOF) begin
            w_p0.cfg.mode = mode_e'(iMode);
            w_p0.cfg.thr  = r_shadow;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_shadow <= THR_DEF;
            r_act    <= '{mode: ModeMask, thr: THR_DEF};
        end else begin
            if (iCfgWe) begin
                unique case (iCfgAddr)
                    2'd0: r_shadow.cr_lo <= iCfgData;
                    2'd1: r_shadow.cr_hi <= iCfgData;
                    2'd2: r_shadow.cb_lo <= iCfgData;
                    2'd3: r_shadow.cb_hi <= iCfgData;
                endcase
            end
            if (iValid && iSOF) begin
                r_act <= w_p0.cfg;
            end
        end
    end

    csc_mac3 #(.DW(DW), .OFF(Y_OFFSET), .K_R(KY_R), .K_G(KY_G), .K_B(KY_B)) u_mac_y (
        .i_clk (iCLK),
        .i_rst (iRST),
        .i_r   (iRed),
        .i_g   (iGreen),
        .i_b   (iBlue),
        .o_res (w_y2)
    );

    csc_mac3 #(.DW(DW), .OFF(C_OFFSET), .K_R(KCB_R), .K_G(KCB_G), .K_B(KCB_B)) u_mac_cb (
        .i_clk (iCLK),
        .i_rst (iRST),
        .i_r   (iRed),
        .i_g   (iGreen),
        .i_b   (iBlue),
        .o_res (w_cb2)
    );

    csc_mac3 #(.DW(DW), .OFF(C_OFFSET), .K_R(KCR_R), .K_G(KCR_G), .K_B(KCR_B)) u_mac_cr (
        .i_clk (iCLK),
        .i_rst (iRST),
        .i_r   (iRed),
        .i_g   (iGreen),
        .i_b   (iBlue),
        .o_res (w_cr2)
    );

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_p1  <= '0;
            r_p2  <= '0;
            r_p3  <= '0;
            r_y3  <= '0;
            r_cb3 <= '0;
            r_cr3 <= '0;
        end else begin
            r_p1  <= w_p0;
            r_p2  <= r_p1;
            r_p3  <= r_p2;
            r_y3  <= clamp_u8(32'(w_y2));
            r_cb3 <= clamp_u8(32'(w_cb2));
            r_cr3 <= clamp_u8(32'(w_cr2));
        end
    end

    always_comb begin
        w_skin = (r_cr3 >= r_p3.cfg.thr.cr_lo) && (r_cr3 <= r_p3.cfg.thr.cr_hi) &&
                 (r_cb3 >= r_p3.cfg.thr.cb_lo) && (r_cb3 <= r_p3.cfg.thr.cb_hi);
        w_r = r_p3.r;
        w_g = r_p3.g;
        w_b = r_p3.b;
        unique case (r_p3.cfg.mode)
            ModeMask: begin
                w_r = w_skin ? MASK_ON : '0;
                w_g = w_skin ? MASK_ON : '0;
                w_b = w_skin ? MASK_ON : '0;
            end
            ModeYcc: begin
                w_r = DW'(r_y3) << (DW - 8);
                w_g = DW'(r_cb3) << (DW - 8);
                w_b = DW'(r_cr3) << (DW - 8);
            end
            ModeSkinRgb: begin
                if (!w_skin) begin
                    w_r = '0;
                    w_g = '0;
                    w_b = '0;
                end
            end
            ModeBypass: begin
            end
        endcase
        w_cnt_base = r_p3.sof ? '0 : r_cnt;
        w_cnt_next = (&w_cnt_base) ? w_cnt_base : w_cnt_base + CNTW'(w_skin);
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oValid      <= 1'b0;
            oSOF        <= 1'b0;
            oEOF        <= 1'b0;
            oRed        <= '0;
            oGreen      <= '0;
            oBlue       <= '0;
            oSkin       <= 1'b0;
            oSkinCount  <= '0;
            oCountValid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            oValid      <= r_p3.v;
            oSOF        <= r_p3.v & r_p3.sof;
            oEOF        <= r_p3.v & r_p3.eof;
            oCountValid <= r_p3.v & r_p3.eof;
            if (r_p3.v) begin
                oRed   <= w_r;
                oGreen <= w_g;
                oBlue  <= w_b;
                oSkin  <= w_skin;
                r_cnt  <= w_cnt_next;
                if (r_p3.eof) begin
                    oSkinCount <= w_cnt_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_ycbcr_skin_filter.sv
// Self-checking bench for ycbcr_skin_filter: directed vectors, frame/counter
// sequences, reset mid-flight, and randomized traffic against a behavioural model.
module tb_ycbcr_skin_filter;

    localparam int DW = 10;

    logic          iCLK = 1'b0;
    logic          iRST = 1'b1;
    logic          iValid = 1'b0, iSOF = 1'b0, iEOF = 1'b0;
    logic [DW-1:0] iRed = '0, iGreen = '0, iBlue = '0;
    logic [1:0]    iMode = '0;
    logic          iCfgWe = 1'b0;
    logic [1:0]    iCfgAddr = '0;
    logic [7:0]    iCfgData = '0;

    logic          oValid, oSOF, oEOF, oSkin, oCountValid;
    logic [DW-1:0] oRed, oGreen, oBlue;
    logic [19:0]   oSkinCount;
    logic          o2Valid, o2SOF, o2EOF, o2Skin, o2CountValid;
    logic [DW-1:0] o2Red, o2Green, o2Blue;
    logic [1:0]    o2SkinCount;

    ycbcr_skin_filter #(.DW(DW), .CNTW(20)) dut (
        .iCLK(iCLK), .iRST(iRST), .iValid(iValid), .iSOF(iSOF), .iEOF(iEOF),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue), .iMode(iMode),
        .iCfgWe(iCfgWe), .iCfgAddr(iCfgAddr), .iCfgData(iCfgData),
        .oValid(oValid), .oSOF(oSOF), .oEOF(oEOF), .oRed(oRed), .oGreen(oGreen),
        .oBlue(oBlue), .oSkin(oSkin), .oSkinCount(oSkinCount), .oCountValid(oCountValid)
    );

    ycbcr_skin_filter #(.DW(DW), .CNTW(2)) dut2 (
        .iCLK(iCLK), .iRST(iRST), .iValid(iValid), .iSOF(iSOF), .iEOF(iEOF),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue), .iMode(iMode),
        .iCfgWe(iCfgWe), .iCfgAddr(iCfgAddr), .iCfgData(iCfgData),
        .oValid(o2Valid), .oSOF(o2SOF), .oEOF(o2EOF), .oRed(o2Red), .oGreen(o2Green),
        .oBlue(o2Blue), .oSkin(o2Skin), .oSkinCount(o2SkinCount),
        .oCountValid(o2CountValid)
    );

    always #5 iCLK = ~iCLK;

    typedef struct { bit v, sof, eof, skin; int r, g, b; } exp_t;
    typedef struct { bit skin, eof, cv; int cnt, cnt2; } cap_t;
    typedef struct { int r, g, b, mode, er, eg, eb; bit es; } vec_t;

    int   errors = 0, checks = 0;
    exp_t m[4];
    cap_t cap[$];
    vec_t vt[8];
    int   def_thr[4] = '{133, 179, 91, 111};
    int   sh[4], act[4], act_mode;
    int   h_r, h_g, h_b, cnt, cnt2, h_count, h_count2;
    bit   h_skin;

    function automatic int conv(int kr, int kg, int kb, int off, int r, int g, int b);
        int s;
        s = kr * r + kg * g + kb * b + (off << (DW + 2));
        s = s >>> (DW + 2);
        return (s < 0) ? 0 : ((s > 255) ? 255 : s);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic check_out(input exp_t e);
        bit   bad;
        cap_t c;
        if (e.v) begin
            h_r = e.r; h_g = e.g; h_b = e.b; h_skin = e.skin;
            if (e.sof) begin
                cnt = int'(e.skin);
                cnt2 = int'(e.skin);
            end else begin
                cnt = (cnt + int'(e.skin) > 1048575) ? 1048575 : cnt + int'(e.skin);
                cnt2 = (cnt2 + int'(e.skin) > 3) ? 3 : cnt2 + int'(e.skin);
            end
            if (e.eof) begin
                h_count = cnt;
                h_count2 = cnt2;
            end
        end
        checks++;
        bad = (oValid !== e.v) || (oSOF !== (e.v && e.sof)) || (oEOF !== (e.v && e.eof)) ||
              (oRed !== DW'(h_r)) || (oGreen !== DW'(h_g)) || (oBlue !== DW'(h_b)) ||
              (oSkin !== h_skin) || (oCountValid !== (e.v && e.eof)) ||
              (oSkinCount !== 20'(h_count));
        if (bad) begin
            errors++;
            $display("FAIL pix @%0t: got v%b s%b e%b rgb=%0d,%0d,%0d skin%b cv%b cnt%0d; expected v%b s%b e%b rgb=%0d,%0d,%0d skin%b cv%b cnt%0d",
                     $time, oValid, oSOF, oEOF, oRed, oGreen, oBlue, oSkin, oCountValid,
                     oSkinCount, e.v, e.v && e.sof, e.v && e.eof, h_r, h_g, h_b, h_skin,
                     e.v && e.eof, h_count);
        end
        checks++;
        bad = (o2Valid !== e.v) || (o2SOF !== (e.v && e.sof)) || (o2EOF !== (e.v && e.eof)) ||
              (o2Red !== DW'(h_r)) || (o2Green !== DW'(h_g)) || (o2Blue !== DW'(h_b)) ||
              (o2Skin !== h_skin) || (o2CountValid !== (e.v && e.eof)) ||
              (o2SkinCount !== 2'(h_count2));
        if (bad) begin
            errors++;
            $display("FAIL pix2 @%0t: got v%b rgb=%0d,%0d,%0d skin%b cv%b cnt%0d; expected v%b rgb=%0d,%0d,%0d skin%b cv%b cnt%0d",
                     $time, o2Valid, o2Red, o2Green, o2Blue, o2Skin, o2CountValid, o2SkinCount,
                     e.v, h_r, h_g, h_b, h_skin, e.v && e.eof, h_count2);
        end
        if (oValid === 1'b1) begin
            c.skin = oSkin; c.eof = oEOF; c.cv = oCountValid;
            c.cnt = int'(oSkinCount); c.cnt2 = int'(o2SkinCount);
            cap.push_back(c);
        end
    endtask

    task automatic cycle(input bit v, input bit sof, input bit eof, input int r, input int g,
                         input int b, input int mode, input bit we, input int addr,
                         input int data);
        exp_t e;
        int   c[4];
        int   md, y, cb, cr;
        iValid = v; iSOF = sof; iEOF = eof;
        iRed = DW'(r); iGreen = DW'(g); iBlue = DW'(b); iMode = 2'(mode);
        iCfgWe = we; iCfgAddr = 2'(addr); iCfgData = 8'(data);
        if (v && sof) begin
            act = sh;
            act_mode = mode;
        end
        c = act;
        md = act_mode;
        y  = conv(263, 516, 100, 16, r, g, b);
        cb = conv(-152, -298, 450, 128, r, g, b);
        cr = conv(450, -377, -73, 128, r, g, b);
        e.v = v; e.sof = sof; e.eof = eof;
        e.skin = (cr >= c[0]) && (cr <= c[1]) && (cb >= c[2]) && (cb <= c[3]);
        case (md)
            0: begin
                e.r = e.skin ? (255 << (DW - 8)) : 0;
                e.g = e.r;
                e.b = e.r;
            end
            1: begin
                e.r = y << (DW - 8);
                e.g = cb << (DW - 8);
                e.b = cr << (DW - 8);
            end
            2: begin
                e.r = e.skin ? r : 0;
                e.g = e.skin ? g : 0;
                e.b = e.skin ? b : 0;
            end
            default: begin
                e.r = r; e.g = g; e.b = b;
            end
        endcase
        if (we) sh[addr] = data;
        m[3] = m[2]; m[2] = m[1]; m[1] = m[0]; m[0] = e;
        @(posedge iCLK);
        #1;
        check_out(m[3]);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic skin_px(input bit sof, input bit eof, input bit skin);
        if (skin) cycle(1, sof, eof, 800, 560, 440, 0, 0, 0, 0);
        else      cycle(1, sof, eof, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        iRST = 1'b1;
        iValid = 0; iSOF = 0; iEOF = 0; iCfgWe = 0;
        #1;
        chk("rst_ctl", 32'({oValid, oSOF, oEOF, oSkin, oCountValid}), 0);
        chk("rst_rgb", 32'({oRed, oGreen, oBlue}), 0);
        chk("rst_cnt", 32'(oSkinCount), 0);
        repeat (2) @(posedge iCLK);
        #1;
        iRST = 1'b0;
        foreach (m[i]) m[i] = '{default: 0};
        h_r = 0; h_g = 0; h_b = 0; h_skin = 0;
        cnt = 0; cnt2 = 0; h_count = 0; h_count2 = 0;
        sh = def_thr; act = def_thr; act_mode = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vt[0] = '{0, 0, 0, 1, 64, 512, 512, 1'b0};
        vt[1] = '{1023, 1023, 1023, 1, 940, 512, 512, 1'b0};
        vt[2] = '{800, 560, 440, 1, 592, 420, 624, 1'b1};
        vt[3] = '{800, 560, 440, 0, 1020, 1020, 1020, 1'b1};
        vt[4] = '{800, 560, 440, 2, 800, 560, 440, 1'b1};
        vt[5] = '{800, 560, 440, 3, 800, 560, 440, 1'b1};
        vt[6] = '{1023, 1023, 1023, 2, 0, 0, 0, 1'b0};
        vt[7] = '{1023, 1023, 1023, 3, 1023, 1023, 1023, 1'b0};

        do_reset();
        repeat (2) idle();

        // Directed single-pixel frames with fixed expected outputs.
        for (int i = 0; i < 8; i++) begin
            cycle(1, 1, 1, vt[i].r, vt[i].g, vt[i].b, vt[i].mode, 0, 0, 0);
            repeat (3) idle();
            chk($sformatf("vec%0d_valid", i), 32'(oValid), 1);
            chk($sformatf("vec%0d_r", i), 32'(oRed), vt[i].er);
            chk($sformatf("vec%0d_g", i), 32'(oGreen), vt[i].eg);
            chk($sformatf("vec%0d_b", i), 32'(oBlue), vt[i].eb);
            chk($sformatf("vec%0d_skin", i), 32'(oSkin), 32'(vt[i].es));
            chk($sformatf("vec%0d_cv", i), 32'(oCountValid), 1);
            chk($sformatf("vec%0d_cnt", i), 32'(oSkinCount), 32'(vt[i].es));
        end

        // Threshold write mid-frame only applies from the next SOF; a write on a SOF
        // cycle is not seen by that SOF.
        cap.delete();
        cycle(1, 1, 0, 800, 560, 440, 0, 0, 0, 0);
        cycle(1, 0, 0, 800, 560, 440, 0, 1, 3, 100);
        cycle(1, 0, 1, 800, 560, 440, 0, 0, 0, 0);
        cycle(1, 1, 1, 800, 560, 440, 0, 1, 3, 111);
        cycle(1, 1, 1, 800, 560, 440, 0, 0, 0, 0);
        repeat (4) idle();
        chk("cfg_caps", cap.size(), 5);
        if (cap.size() == 5) begin
            chk("cfg_cur0", 32'(cap[0].skin), 1);
            chk("cfg_cur2", 32'(cap[2].skin), 1);
            chk("cfg_next", 32'(cap[3].skin), 0);
            chk("cfg_restore", 32'(cap[4].skin), 1);
        end

        // 10-pixel frame, 6 skin, one bubble.
        cap.delete();
        skin_px(1, 0, 1); skin_px(0, 0, 0); skin_px(0, 0, 1); skin_px(0, 0, 1);
        skin_px(0, 0, 0);
        idle();
        skin_px(0, 0, 1); skin_px(0, 0, 0); skin_px(0, 0, 1); skin_px(0, 0, 1);
        skin_px(0, 1, 0);
        repeat (4) idle();
        chk("f10_caps", cap.size(), 10);
        if (cap.size() == 10) begin
            chk("f10_eof", 32'(cap[9].eof), 1);
            chk("f10_cv", 32'(cap[9].cv), 1);
            chk("f10_cnt", cap[9].cnt, 6);
            chk("f10_cnt_sat", cap[9].cnt2, 3);
            chk("f10_cv_early", 32'(cap[8].cv), 0);
        end

        // 6-pixel frame with 5 skin pixels; 2-bit counter saturates.
        cap.delete();
        skin_px(1, 0, 1); skin_px(0, 0, 1); skin_px(0, 0, 1); skin_px(0, 0, 0);
        skin_px(0, 0, 1); skin_px(0, 1, 1);
        repeat (4) idle();
        chk("f6_caps", cap.size(), 6);
        if (cap.size() == 6) begin
            chk("f6_cnt", cap[5].cnt, 5);
            chk("f6_cnt_sat", cap[5].cnt2, 3);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bit v, sof, eof, we;
            int r, g, b, mode, addr, data;
            v = ($urandom_range(0, 3) != 0);
            sof = ($urandom_range(0, 9) == 0);
            eof = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 1) == 1) begin
                r = $urandom_range(760, 840);
                g = $urandom_range(520, 600);
                b = $urandom_range(400, 480);
            end else begin
                r = $urandom_range(0, 1023);
                g = $urandom_range(0, 1023);
                b = $urandom_range(0, 1023);
            end
            mode = $urandom_range(0, 3);
            we = ($urandom_range(0, 15) == 0);
            addr = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                data = def_thr[addr] + $urandom_range(0, 40) - 20;
            end else begin
                data = $urandom_range(0, 255);
            end
            cycle(v, sof, eof, r, g, b, mode, we, addr, data);
        end
        repeat (4) idle();

        // Reset with 3 pixels in flight and a non-default active threshold.
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 3, 100);
        cycle(1, 1, 0, 800, 560, 440, 0, 0, 0, 0);
        cycle(1, 0, 0, 800, 560, 440, 0, 0, 0, 0);
        cycle(1, 0, 0, 800, 560, 440, 0, 0, 0, 0);
        do_reset();
        cap.delete();
        repeat (6) idle();
        chk("rst_no_valid", cap.size(), 0);
        cycle(1, 1, 1, 800, 560, 440, 0, 0, 0, 0);
        repeat (3) idle();
        chk("rst_thr_valid", 32'(oValid), 1);
        chk("rst_thr_skin", 32'(oSkin), 1);
        chk("rst_thr_rgb", 32'(oRed), 1020);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
